// File: rtl/segled_serial_rx_pkg.sv
// Shared definitions for the serial segment/LED display receiver:
// byte width, receiver FSM states and the active-low hex glyph decoder.
package segled_pkg;

  localparam int SEG_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } rx_state_e;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic       ok;
    logic [3:0] value;
  } glyph_dec_t;

  // Map a 7-segment pattern to its hex value; ok=0 and value=0 on no match.
  function automatic glyph_dec_t decode_glyph(input logic [6:0] seg);
    glyph_dec_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH[i]) begin
        r.ok    = 1'b1;
        r.value = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/segled_serial_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous serial line, followed by a
// history flop so a rising edge shows up as a single-cycle pulse.
module segled_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  // Shift the raw line through the synchronizer and keep one cycle of history.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  // Synchronizer and history registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign sync = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/segled_serial_rx.sv
// Receiver for the SEGLED_CLK / SEGLED_DO / SEGLED_PEN display stream.
// Oversamples the three lines, shifts in one frame MSB-first and presents
// it in parallel on each PEN strobe, flagging short, long and stalled frames.
// Optional: define SEGLED_SERIAL_RX_DECODE_EN to add registered hex-digit
// decode of the latched frame (hex_digits / hex_ok ports).
// rst asserts asynchronously; its release is expected synchronous to clk.
module segled_serial_rx
  import segled_pkg::*;
#(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_in,
  input  logic                  sdo_in,
  input  logic                  pen_in,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      bit_count,
  output logic                  busy
`ifdef SEGLED_SERIAL_RX_DECODE_EN
  , output logic [4*(FRAME_BITS/SEG_BYTE_W)-1:0] hex_digits
  , output logic [FRAME_BITS/SEG_BYTE_W-1:0]     hex_ok
`endif
);

  localparam int               TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  // Synchronized line events; the sync levels of sclk/pen and the edge of
  // sdo are produced by the shared cell but have no use here.
  logic sclk_rise, pen_rise, sdo_sync;
  logic sclk_sync_unused, pen_sync_unused, sdo_rise_unused;

  segled_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (sclk_in), .sync (sclk_sync_unused), .rise (sclk_rise)
  );
  segled_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdo (
    .clk (clk), .rst (rst), .d (sdo_in), .sync (sdo_sync), .rise (sdo_rise_unused)
  );
  segled_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pen (
    .clk (clk), .rst (rst), .d (pen_in), .sync (pen_sync_unused), .rise (pen_rise)
  );

  rx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  timeout_hit;

  // A stalled partial frame aborts only when nothing else is happening.
  assign timeout_hit = (state_q == SHIFT) && !sclk_rise && !pen_rise && (tmo_q == TMO_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sclk_rise) state_d = SHIFT;
      SHIFT: begin
        if (pen_rise)         state_d = LATCH;
        else if (timeout_hit) state_d = IDLE;
      end
      LATCH:   state_d = sclk_rise ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: latch or reject in LATCH, reject on timeout, busy in SHIFT.
  always_comb begin
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    busy          = (state_q == SHIFT);
    if (state_q == LATCH) begin
      if (cnt_q == CNT_FULL && !ovf_q) begin
        frame_data_d  = shreg_q;
        frame_valid_d = 1'b1;
      end else begin
        frame_err_d   = 1'b1;
      end
    end else if (timeout_hit) begin
      frame_err_d = 1'b1;
    end
  end

  // Shift register, saturating bit counter, overflow flag and stall timer.
  always_comb begin
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    // Leaving LATCH starts a fresh frame, so count from zero there.
    base_cnt = (state_q == LATCH) ? '0 : cnt_q;
    base_ovf = (state_q == LATCH) ? 1'b0 : ovf_q;
    shreg_d  = shreg_q;
    cnt_d    = base_cnt;
    ovf_d    = base_ovf;
    tmo_d    = '0;
    if (sclk_rise) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], sdo_sync};
      if (base_cnt >= CNT_FULL) ovf_d = 1'b1;
      if (base_cnt != CNT_SAT)  cnt_d = base_cnt + CNT_W'(1);
    end
    if (state_q == SHIFT && !sclk_rise) tmo_d = tmo_q + TMO_W'(1);
    if (timeout_hit) begin
      shreg_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      tmo_d   = '0;
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q       <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      tmo_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      tmo_q         <= tmo_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign bit_count   = cnt_q;

`ifdef SEGLED_SERIAL_RX_DECODE_EN
  localparam int NUM_DIGITS = FRAME_BITS / SEG_BYTE_W;

  logic [4*NUM_DIGITS-1:0] hex_digits_q, hex_digits_d;
  logic [NUM_DIGITS-1:0]   hex_ok_q, hex_ok_d;

  // Decode each latched byte's segment bits the cycle after a good frame.
  always_comb begin
    glyph_dec_t dec;
    dec          = '0;
    hex_digits_d = hex_digits_q;
    hex_ok_d     = hex_ok_q;
    if (frame_valid_q) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dec = decode_glyph(frame_data_q[SEG_BYTE_W*i +: 7]);
        hex_digits_d[4*i +: 4] = dec.value;
        hex_ok_d[i]            = dec.ok;
      end
    end
  end

  // Decoded digit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_digits_q <= '0;
      hex_ok_q     <= '0;
    end else begin
      hex_digits_q <= hex_digits_d;
      hex_ok_q     <= hex_ok_d;
    end
  end

  assign hex_digits = hex_digits_q;
  assign hex_ok     = hex_ok_q;
`endif

endmodule

// File: tb/tb_segled_serial_rx.sv
// Self-checking bench for segled_serial_rx: drives serial frames, predicts
// each frame_valid / frame_err event into a scoreboard queue and compares
// as the DUT reports them. Decode checks are built when
// SEGLED_SERIAL_RX_DECODE_EN is defined.
module tb_segled_serial_rx;

  localparam int FRAME_BITS = 64;
  localparam int CNT_W      = 7;
  localparam int HALF       = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  sclk_in, sdo_in, pen_in;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid, frame_err, busy;
  logic [CNT_W-1:0]      bit_count;
`ifdef SEGLED_SERIAL_RX_DECODE_EN
  logic [31:0]           hex_digits;
  logic [7:0]            hex_ok;
`endif

  segled_serial_rx #(
    .FRAME_BITS (FRAME_BITS), .SYNC_STAGES (2), .TIMEOUT (1024), .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk_in     (sclk_in),
    .sdo_in      (sdo_in),
    .pen_in      (pen_in),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .bit_count   (bit_count),
    .busy        (busy)
`ifdef SEGLED_SERIAL_RX_DECODE_EN
    , .hex_digits (hex_digits)
    , .hex_ok     (hex_ok)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                  is_err;
    logic [FRAME_BITS-1:0] data;
  } exp_t;

  exp_t                  sb_q[$];
  exp_t                  exp_item;
  logic [FRAME_BITS-1:0] last_good = '0;
  int                    n_vec = 0;
  int                    n_err = 0;

  // Scoreboard monitor: every frame event must match the oldest prediction.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (frame_valid && frame_err) begin
        n_vec++; n_err++;
        $display("FAIL excl: frame_valid and frame_err both high");
      end
      if (frame_valid || frame_err) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: valid=%0b err=%0b data=%h, none required",
                   frame_valid, frame_err, frame_data);
        end else begin
          exp_item = sb_q.pop_front();
          if (frame_err !== exp_item.is_err || frame_data !== exp_item.data) begin
            n_err++;
            $display("FAIL frame_event: got err=%0b data=%h, required err=%0b data=%h",
                     frame_err, frame_data, exp_item.is_err, exp_item.data);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_expect(input logic is_err, input logic [FRAME_BITS-1:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = is_err ? last_good : data;
    if (!is_err) last_good = data;
    sb_q.push_back(e);
  endtask

  // Send the low n bits of v MSB-first; sclk is left low afterwards.
  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdo_in = v[i]; sclk_in = 1'b0; tick(HALF);
      sclk_in = 1'b1; tick(HALF);
    end
    sclk_in = 1'b0; tick(HALF);
  endtask

  task automatic pulse_pen();
    pen_in = 1'b1; tick(HALF);
    pen_in = 1'b0; tick(HALF);
  endtask

  task automatic wait_done(input int budget, input string name);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < budget) begin
      @(negedge clk); i++;
    end
    tick(2);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d events outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    n_vec++;
    if (busy !== 1'b0 || bit_count !== '0) begin
      n_err++;
      $display("FAIL %s: busy=%0b bit_count=%0d, required busy=0 bit_count=0",
               name, busy, bit_count);
    end
  endtask

  task automatic good_frame(input logic [FRAME_BITS-1:0] d, input string name);
    push_expect(1'b0, d);
    send_bits(128'(d), FRAME_BITS);
    pulse_pen();
    wait_done(40, name);
    check_idle({name, "_idle"});
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk_in = 1'b0; sdo_in = 1'b0; pen_in = 1'b0;
    tick(3);
    n_vec++;
    if (frame_data !== '0 || frame_valid !== 1'b0 || frame_err !== 1'b0 ||
        bit_count !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: data=%h v=%0b e=%0b cnt=%0d busy=%0b, required all 0",
               frame_data, frame_valid, frame_err, bit_count, busy);
    end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_good_frame();
    good_frame(64'h0123_4567_89AB_CDEF, "good_frame");
  endtask

  task automatic test_short_frame();
    push_expect(1'b1, '0);
    send_bits(128'(64'h5555_AAAA_5555_AAAA), 63);
    n_vec++;
    if (bit_count !== 7'd63 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL short_count: bit_count=%0d busy=%0b, required 63 busy=1", bit_count, busy);
    end
    pulse_pen();
    wait_done(40, "short_frame");
    check_idle("short_idle");
  endtask

  task automatic test_long_frame();
    push_expect(1'b1, '0);
    send_bits({63'd0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D}, 65);
    n_vec++;
    if (bit_count !== 7'd65) begin
      n_err++;
      $display("FAIL long_count: bit_count=%0d, required 65", bit_count);
    end
    pulse_pen();
    wait_done(40, "long_frame");
  endtask

  task automatic test_saturate();
    push_expect(1'b1, '0);
    send_bits({62'd0, 2'b11, 64'h1}, 66);
    n_vec++;
    if (bit_count !== 7'd65) begin
      n_err++;
      $display("FAIL saturate_count: bit_count=%0d, required 65", bit_count);
    end
    pulse_pen();
    wait_done(40, "saturate");
  endtask

  task automatic test_timeout();
    push_expect(1'b1, '0);
    send_bits(128'(10'h2A5), 10);
    wait_done(1024 + 200, "timeout");
    check_idle("timeout_idle");
    good_frame(64'hA5A5_0F0F_3C3C_9669, "after_timeout");
  endtask

  task automatic test_simultaneous();
    logic [FRAME_BITS-1:0] d;
    d = 64'h8000_0000_0000_0001;
    push_expect(1'b0, d);
    send_bits(128'(d >> 1), FRAME_BITS - 1);
    sdo_in = d[0]; sclk_in = 1'b0; tick(HALF);
    sclk_in = 1'b1; pen_in = 1'b1; tick(HALF);
    sclk_in = 1'b0; pen_in = 1'b0; tick(HALF);
    wait_done(40, "simultaneous");
  endtask

  task automatic test_reset_mid_frame();
    send_bits(128'(30'h3ABC_1234), 30);
    rst = 1'b1;
    tick(2);
    n_vec++;
    if (frame_data !== '0 || frame_valid !== 1'b0 || frame_err !== 1'b0 ||
        bit_count !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: data=%h v=%0b e=%0b cnt=%0d busy=%0b, required all 0",
               frame_data, frame_valid, frame_err, bit_count, busy);
    end
    last_good = '0;
    rst = 1'b0;
    tick(3);
    good_frame(64'hFEDC_BA98_7654_3210, "after_reset");
  endtask

`ifdef SEGLED_SERIAL_RX_DECODE_EN
  task automatic test_decode();
    good_frame({8{8'hC0}}, "decode_zero_frame");
    n_vec++;
    if (hex_digits !== 32'h0 || hex_ok !== 8'hFF) begin
      n_err++;
      $display("FAIL decode_zero: digits=%h ok=%h, required 00000000 ff", hex_digits, hex_ok);
    end
    good_frame({8'h8E, 8'h92, 8'hC0, 8'hF9, 8'h88, 8'hC6, 8'hC0, 8'hFF}, "decode_mix_frame");
    n_vec++;
    if (hex_digits !== 32'hF5_01_AC_00 || hex_ok !== 8'hFE) begin
      n_err++;
      $display("FAIL decode_mix: digits=%h ok=%h, required f501ac00 fe", hex_digits, hex_ok);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_saturate();
    test_timeout();
    test_simultaneous();
    test_reset_mid_frame();
`ifdef SEGLED_SERIAL_RX_DECODE_EN
    test_decode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
